// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_generator
//  Brief    : Captures a switch word on a button rise and sends it LSB-first
//             on one serial line with a per-bit strobe.
//  Revision : 1.0
// ============================================================================
module sequence_generator #(
  parameter int BIT_PERIOD = 2,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_button,
  input  logic [WIDTH-1:0] i_switch,
  input  logic             i_loop,
  output logic             o_serial_out,
  output logic             o_bit_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int c_CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int c_IDX_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIT_PERIOD - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_shift_nx;
  logic [c_CNT_W-1:0] w_cnt_nx;
  logic [c_IDX_W-1:0] w_idx_nx;
  logic               w_valid_nx;
  logic               w_busy_nx;
  logic               w_done_nx;
  logic               w_load;
  logic               w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_valid_nx = 1'b0;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_load     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_load = 1'b1;
        end else begin
          w_shift_nx = '0;
          w_busy_nx  = 1'b0;
        end
      end
      ST_SHIFT: begin
        // A restart wins over every other event, including frame end.
        if (w_rise) begin
          w_load = 1'b1;
        end else if (r_cnt != c_CNT_LAST) begin
          w_cnt_nx = r_cnt + 1'b1;
        end else if (r_idx != c_IDX_LAST) begin
          w_shift_nx = r_shift >> 1;
          w_idx_nx   = r_idx + 1'b1;
          w_cnt_nx   = '0;
          w_valid_nx = 1'b1;
        end else begin
          w_done_nx = 1'b1;
          if (i_loop) begin
            w_load = 1'b1;
          end else begin
            w_shift_nx = '0;
            w_busy_nx  = 1'b0;
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    if (w_load) begin
      w_state_nx = ST_SHIFT;
      w_shift_nx = i_switch;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
      w_valid_nx = 1'b1;
      w_busy_nx  = 1'b1;
    end
  end

  // The shift register is cleared whenever idle, so its LSB is the serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_valid <= w_valid_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign o_serial_out = r_shift[0];
  assign o_bit_valid  = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sequence_generator
//  Brief    : Directed bench with a frame-level reference model for P=2 and
//             literal checks for the P=1 corner.
//  Revision : 1.0
// ============================================================================
module tb_sequence_generator;
  localparam int P = 2;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       button = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       loop = 1'b0;
  logic       so, bv, busy, done;

  logic       button1 = 1'b0;
  logic [7:0] sw1 = 8'h00;
  logic       loop1 = 1'b0;
  logic       so1, bv1, busy1, done1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  sequence_generator #(.BIT_PERIOD(P), .WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_button(button), .i_switch(sw), .i_loop(loop),
    .o_serial_out(so), .o_bit_valid(bv), .o_busy(busy), .o_done(done)
  );

  sequence_generator #(.BIT_PERIOD(1), .WIDTH(8)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .i_button(button1), .i_switch(sw1), .i_loop(loop1),
    .o_serial_out(so1), .o_bit_valid(bv1), .o_busy(busy1), .o_done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a button sample high at edge k starts a frame at k+2;
  // thereafter only the elapsed cycle count and the captured word matter.
  logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic       m_rise;
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_d = 8'h00;
  logic       m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      m_act = 1'b0; m_t = 0; m_d = 8'h00; m_done = 1'b0;
    end else begin
      m_rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = button;
      m_done = 1'b0;
      if (m_rise) begin
        m_d = sw; m_t = 0; m_act = 1'b1;
      end else if (m_act) begin
        m_t++;
        if (m_t == W * P) begin
          m_done = 1'b1;
          m_t = 0;
          if (loop) m_d = sw;
          else m_act = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk1("model serial_out", so,   m_act ? m_d[m_t / P] : 1'b0);
      chk1("model bit_valid",  bv,   m_act && (m_t % P == 0));
      chk1("model busy",       busy, m_act);
      chk1("model done",       done, m_done);
    end
  end

  task automatic wait_done(input int lim, output int t);
    bit ok = 1'b0;
    t = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL done timeout: no done within %0d cycles (cycle %0d)", lim, cyc);
    end
  endtask

  initial begin
    int         exp_b4 [8] = '{0, 0, 1, 0, 1, 1, 0, 1};
    logic [7:0] got;
    int         nb, busy_cnt, done_cnt, done_c, ones;
    int         t1, t2, t3;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk1("reset serial_out", so, 1'b0);
    chk1("reset bit_valid", bv, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame of 8'hB4
    sw = 8'hB4; loop = 1'b0; button = 1'b1;
    @(negedge clk); button = 1'b0;
    @(negedge clk);
    got = 8'h00; nb = 0; busy_cnt = 0; done_cnt = 0; done_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bv) begin
        if (nb < 8) got[nb] = so;
        nb++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_c = c;
      end
    end
    chk32("single valid pulses", nb, 8);
    chk32("single busy cycles", busy_cnt, 16);
    chk32("single done count", done_cnt, 1);
    chk32("single done edge offset", done_c, 16);
    for (int i = 0; i < 8; i++) chk1("single bit", got[i], exp_b4[i][0]);
    chk1("single idle serial", so, 1'b0);

    // Loop mode with 8'hA5
    sw = 8'hA5; loop = 1'b1; button = 1'b1;
    @(negedge clk); button = 1'b0;
    wait_done(30, t1);
    wait_done(30, t2);
    chk32("loop done spacing", t2 - t1, 16);
    repeat (5) @(negedge clk);
    loop = 1'b0;
    wait_done(30, t3);
    chk32("loop final spacing", t3 - t2, 16);
    chk1("loop end busy", busy, 1'b0);
    @(negedge clk);
    chk1("loop idle busy", busy, 1'b0);
    chk1("loop idle serial", so, 1'b0);
    repeat (4) @(negedge clk);

    // Mid-frame restart: FF frame aborted during bit 3 by a 00 frame
    sw = 8'hFF; button = 1'b1;
    @(negedge clk); button = 1'b0;
    repeat (8) @(negedge clk);
    sw = 8'h00; button = 1'b1;
    @(negedge clk); button = 1'b0;
    ones = 0; busy_cnt = 0; done_cnt = 0; done_c = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 17) begin
        if (so) ones++;
        if (busy) busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
    end
    chk32("restart ones in new frame", ones, 0);
    chk32("restart busy cycles", busy_cnt, 16);
    chk32("restart done count", done_cnt, 1);
    chk32("restart done offset", done_c, 18);

    // Asynchronous reset during bit 5
    sw = 8'h3C; button = 1'b1;
    @(negedge clk); button = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("async rst serial_out", so, 1'b0);
    chk1("async rst bit_valid", bv, 1'b0);
    chk1("async rst busy", busy, 1'b0);
    chk1("async rst done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    busy_cnt = 0; done_cnt = 0; nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (bv) nb++;
    end
    chk32("post-reset busy", busy_cnt, 0);
    chk32("post-reset done", done_cnt, 0);
    chk32("post-reset valid", nb, 0);

    // Held button with switch changing mid-frame
    sw = 8'h5A; button = 1'b1;
    got = 8'h00; nb = 0; done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 10) sw = 8'hFF;
      if (c == 39) button = 1'b0;
      if (bv) begin
        if (nb < 8) got[nb] = so;
        nb++;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk32("held data", int'(got), 32'h5A);
    chk32("held valid pulses", nb, 8);
    chk32("held done count", done_cnt, 1);
    chk32("held busy cycles", busy_cnt, 16);

    // BIT_PERIOD = 1 corner, switch = 8'h01
    sw1 = 8'h01; button1 = 1'b1;
    @(negedge clk); button1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk1("p1 serial_out", so1, c == 2);
      chk1("p1 bit_valid", bv1, c >= 2 && c <= 9);
      chk1("p1 busy", busy1, c >= 2 && c <= 9);
      chk1("p1 done", done1, c == 10);
    end

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
